// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer for a word-addressed synchronous data RAM
module mem_access_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic              req_signed,
  input  logic              req_byte,
  input  logic              req_half,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t      state;
  logic [2:0]  lat_cnt;
  logic        lat_load;
  logic        lat_signed;
  logic        lat_byte;
  logic        lat_half;
  logic [1:0]  lat_lane;

  logic        sel_byte;
  logic        sel_half;
  logic        misaligned;
  logic [1:0]  lane;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic [31:0] ld_shift;
  logic [31:0] ld_ext;
  logic        unused_addr_hi;

  assign req_ready      = (state == IDLE);
  assign stall          = req_valid & ~resp_valid;
  assign lane           = req_addr[1:0];
  assign sel_byte       = req_byte;
  assign sel_half       = ~req_byte & req_half;
  assign misaligned     = (sel_half & req_addr[0]) |
                          (~req_byte & ~req_half & (req_addr[1:0] != 2'b00));
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Stores replicate the narrow value across all lanes; the byte enables pick the lane.
  always_comb begin
    st_we    = 4'b1111;
    st_wdata = req_wdata;
    if (sel_byte) begin
      st_we    = 4'b0001 << lane;
      st_wdata = {4{req_wdata[7:0]}};
    end else if (sel_half) begin
      st_we    = 4'b0011 << lane;
      st_wdata = {2{req_wdata[15:0]}};
    end
  end

  assign ld_shift = mem_rdata >> {lat_lane, 3'b000};

  always_comb begin
    ld_ext = ld_shift;
    if (lat_byte) begin
      ld_ext = {{24{lat_signed & ld_shift[7]}}, ld_shift[7:0]};
    end else if (lat_half) begin
      ld_ext = {{16{lat_signed & ld_shift[15]}}, ld_shift[15:0]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= 3'd0;
      lat_load   <= 1'b0;
      lat_signed <= 1'b0;
      lat_byte   <= 1'b0;
      lat_half   <= 1'b0;
      lat_lane   <= 2'b00;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 4'b0000;
      mem_wdata  <= 32'd0;
    end else begin
      mem_re     <= 1'b0;
      mem_we     <= 4'b0000;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_load   <= req_load;
            lat_signed <= req_signed;
            lat_byte   <= sel_byte;
            lat_half   <= sel_half;
            lat_lane   <= lane;
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state    <= ACCESS;
              mem_addr <= req_addr[ADDR_W+1:2];
              if (req_load) begin
                mem_re <= 1'b1;
              end else begin
                mem_we    <= st_we;
                mem_wdata <= st_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (lat_load) begin
            state   <= WAIT;
            lat_cnt <= 3'(MEM_LAT);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
          end
        end
        // The counter reaching 1 marks the cycle the RAM data is valid.
        WAIT: begin
          if (lat_cnt == 3'd1) begin
            state      <= RESP;
            lat_cnt    <= 3'd0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= ld_ext;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl at MEM_LAT 1 and 3
module tb_mem_access_ctrl;

  localparam int LATS [2] = '{1, 3};

  typedef struct {
    int          k;
    logic        err;
    logic [31:0] rdata;
    int          cycle;
  } resp_t;

  typedef struct {
    int          k;
    logic        re;
    logic [3:0]  we;
    logic [13:0] addr;
    logic [31:0] wdata;
    int          cycle;
  } strb_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid  [2];
  logic        req_load   [2];
  logic        req_signed [2];
  logic        req_byte   [2];
  logic        req_half   [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        stall      [2];
  logic        resp_valid [2];
  logic        resp_err   [2];
  logic [31:0] resp_rdata [2];
  logic [13:0] mem_addr   [2];
  logic        mem_re     [2];
  logic [3:0]  mem_we     [2];
  logic [31:0] mem_wdata  [2];
  logic [31:0] mem_rdata  [2];

  logic [31:0] ram     [2][16];
  logic [31:0] pipe    [2][3];
  logic [7:0]  bytes_m [2][64];

  resp_t resp_q[$];
  strb_t strb_q[$];
  int    cyc    = 0;
  int    errors = 0;
  int    checks = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_access_ctrl #(.ADDR_W(14), .MEM_LAT(g == 0 ? 1 : 3)) u_dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_load   (req_load[g]),
      .req_signed (req_signed[g]),
      .req_byte   (req_byte[g]),
      .req_half   (req_half[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_ready  (req_ready[g]),
      .stall      (stall[g]),
      .resp_valid (resp_valid[g]),
      .resp_err   (resp_err[g]),
      .resp_rdata (resp_rdata[g]),
      .mem_addr   (mem_addr[g]),
      .mem_re     (mem_re[g]),
      .mem_we     (mem_we[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g])
    );
  end

  function automatic logic [31:0] init_word(input int k, input int w);
    if (k == 0 && w == 4) return 32'h80FF_1234;
    if (k == 1 && w == 0) return 32'h8001_0000;
    return (32'h9E37_79B9 * 32'(w + 1)) ^ (k == 1 ? 32'h5A5A_0F0F : 32'h0);
  endfunction

  // RAM device: read data appears after the instance's latency, garbage otherwise.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int w = 0; w < 16; w++) ram[k][w] <= init_word(k, w);
      end else begin
        for (int i = 0; i < 4; i++)
          if (mem_we[k][i]) ram[k][mem_addr[k][3:0]][8*i +: 8] <= mem_wdata[k][8*i +: 8];
      end
      pipe[k][0] <= mem_re[k] ? ram[k][mem_addr[k][3:0]] : $urandom;
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_init();
    logic [31:0] w32;
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 16; w++) begin
        w32 = init_word(k, w);
        for (int i = 0; i < 4; i++) bytes_m[k][4*w+i] = w32[8*i +: 8];
      end
  endtask

  task automatic check_idle(input int k);
    check("idle_req_ready", req_ready[k], 1);
    check("idle_resp_valid", resp_valid[k], 0);
    check("idle_resp_err", resp_err[k], 0);
    check("idle_resp_rdata", resp_rdata[k], 0);
    check("idle_mem_re", mem_re[k], 0);
    check("idle_mem_we", mem_we[k], 0);
    check("idle_mem_wdata", mem_wdata[k], 0);
    check("idle_mem_addr", mem_addr[k], 0);
  endtask

  // Issue one access; expectations come from a byte-addressed memory model.
  task automatic do_req(input int k, input bit ld, input bit sg, input bit bt, input bit hf,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int          size;
    int          off;
    int          e_cyc;
    logic        err;
    logic [31:0] rd;
    longint      v;
    resp_t       r;
    strb_t       s;
    bit          done;
    check("req_ready", req_ready[k], 1);
    req_load[k]   = ld;
    req_signed[k] = sg;
    req_byte[k]   = bt;
    req_half[k]   = hf;
    req_addr[k]   = addr;
    req_wdata[k]  = wdata;
    req_valid[k]  = 1'b1;
    size  = bt ? 1 : (hf ? 2 : 4);
    off   = int'(addr[5:0]);
    err   = (off % size) != 0;
    e_cyc = cyc + 1;
    rd    = 32'd0;
    if (!err) begin
      s.k     = k;
      s.re    = ld;
      s.addr  = addr[15:2];
      s.cycle = e_cyc;
      s.we    = 4'b0000;
      s.wdata = 32'd0;
      if (ld) begin
        v = 0;
        for (int i = 0; i < size; i++) v = v | (longint'(bytes_m[k][off+i]) << (8*i));
        if (sg && size < 4 && v[8*size-1]) v = v | (~64'd0 << (8*size));
        rd = v[31:0];
      end else begin
        s.we = 4'(((1 << size) - 1) << (off % 4));
        for (int j = 0; j < 4; j++) s.wdata[8*j +: 8] = wdata[8*(j % size) +: 8];
        for (int i = 0; i < size; i++) bytes_m[k][off+i] = wdata[8*i +: 8];
      end
      strb_q.push_back(s);
    end
    r.k     = k;
    r.err   = err;
    r.rdata = rd;
    r.cycle = err ? e_cyc : (ld ? e_cyc + 1 + LATS[k] : e_cyc + 1);
    resp_q.push_back(r);
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(posedge clock); #1;
      if (resp_valid[k]) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: inst %0d no resp_valid within 20 cycles", k);
    end
    @(posedge clock); #1;
    req_valid[k] = 1'b0;
  endtask

  // Monitor: compares every response and every RAM strobe against the scoreboard.
  always @(negedge clock) begin
    resp_t re_e;
    strb_t st_e;
    logic  exp_stall;
    for (int k = 0; k < 2; k++) begin
      exp_stall = req_valid[k] &&
                  !(resp_q.size() > 0 && resp_q[0].k == k && resp_q[0].cycle == cyc);
      check("stall", stall[k], exp_stall);
      if (resp_valid[k]) begin
        if (resp_q.size() == 0 || resp_q[0].k != k) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: inst %0d got resp_valid=1 expected none (cycle %0d)", k, cyc);
        end else begin
          re_e = resp_q.pop_front();
          check("resp_cycle", 32'(cyc), 32'(re_e.cycle));
          check("resp_err", resp_err[k], re_e.err);
          check("resp_rdata", resp_rdata[k], re_e.rdata);
        end
      end
      if (mem_re[k] || mem_we[k] != 4'b0000) begin
        if (strb_q.size() == 0 || strb_q[0].k != k) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: inst %0d got re=%0b we=%04b expected none (cycle %0d)",
                   k, mem_re[k], mem_we[k], cyc);
        end else begin
          st_e = strb_q.pop_front();
          check("strobe_cycle", 32'(cyc), 32'(st_e.cycle));
          check("mem_re", mem_re[k], st_e.re);
          check("mem_we", mem_we[k], st_e.we);
          check("mem_addr", mem_addr[k], st_e.addr);
          if (!st_e.re) check("mem_wdata", mem_wdata[k], st_e.wdata);
        end
      end
    end
  end

  task automatic random_reqs(input int k, input int count);
    for (int n = 0; n < count; n++)
      do_req(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 63)),
             $urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_load[k] = 1'b0; req_signed[k] = 1'b0; req_byte[k] = 1'b0;
      req_half[k]  = 1'b0; req_addr[k] = 32'd0; req_wdata[k] = 32'd0;
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    model_init();
    check_idle(0);
    check_idle(1);

    do_req(0, 1, 1, 1, 0, 32'h0000_0013, 32'd0);
    do_req(0, 0, 0, 0, 1, 32'h0000_0006, 32'h1234_BEEF);
    do_req(0, 1, 0, 0, 0, 32'h0000_0002, 32'd0);
    random_reqs(0, 60);

    do_req(1, 1, 0, 0, 1, 32'h0000_0002, 32'd0);

    check("abort_req_ready", req_ready[1], 1);
    req_load[1] = 1'b1; req_signed[1] = 1'b0; req_byte[1] = 1'b0; req_half[1] = 1'b0;
    req_addr[1] = 32'h0000_0008; req_valid[1] = 1'b1;
    strb_q.push_back('{k: 1, re: 1'b1, we: 4'b0000, addr: 14'd2, wdata: 32'd0, cycle: cyc + 1});
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    req_valid[1] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    model_init();
    check_idle(1);
    check_idle(0);
    repeat (8) @(posedge clock);
    #1;

    do_req(1, 0, 0, 1, 0, 32'h0000_0009, 32'h0000_005A);
    do_req(1, 1, 0, 1, 0, 32'h0000_0009, 32'd0);
    random_reqs(1, 60);

    repeat (10) @(posedge clock);
    #1;
    check("resp_q_empty", 32'(resp_q.size()), 0);
    check("strb_q_empty", 32'(strb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
